taillight_sequencer: RTL and testbench

- Sequencing controller for the six Thunderbird tail lamps (la/lb/lc left, ra/rb/rc right).
- Latches turn requests, arbitrates between left, right and hazard, and paces the lamp pattern with an internal tick prescaler.
- Applies a brake overlay and drives the lamp outputs.
- Sits between the driver switch inputs and the lamp drivers; replaces direct switch-to-FSM wiring.

---
 rtl/thunderbird_pkg.sv | 61 ++++++
 rtl/tick_prescaler.sv | 30 +++
 rtl/taillight_sequencer.sv | 103 ++++++++++
 tb/tb_taillight_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/thunderbird_pkg.sv
// Shared definitions for the Thunderbird tail-lamp sequencer.
//   - state_t    : one-hot FSM state encoding (9 states)
//   - LAMP_*     : 6-bit lamp patterns, ordered {lc,lb,la,ra,rb,rc}
//   - BRAKE_L/R  : brake overlay masks for the left / right lamp banks
//   - lamp_decode: pattern for a given state with the brake overlay applied
package thunderbird_pkg;

    localparam int unsigned NUM_STATES = 9;

    typedef enum logic [NUM_STATES-1:0] {
        StIdle   = 9'b0_0000_0001,
        StL1     = 9'b0_0000_0010,
        StL2     = 9'b0_0000_0100,
        StL3     = 9'b0_0000_1000,
        StR1     = 9'b0_0001_0000,
        StR2     = 9'b0_0010_0000,
        StR3     = 9'b0_0100_0000,
        StHazOn  = 9'b0_1000_0000,
        StHazOff = 9'b1_0000_0000
    } state_t;

    // Bit order {lc,lb,la,ra,rb,rc}: outer-left to outer-right.
    localparam logic [5:0] LAMP_OFF = 6'b000_000;
    localparam logic [5:0] LAMP_ALL = 6'b111_111;
    localparam logic [5:0] LAMP_L1  = 6'b001_000;
    localparam logic [5:0] LAMP_L2  = 6'b011_000;
    localparam logic [5:0] LAMP_L3  = 6'b111_000;
    localparam logic [5:0] LAMP_R1  = 6'b000_100;
    localparam logic [5:0] LAMP_R2  = 6'b000_110;
    localparam logic [5:0] LAMP_R3  = 6'b000_111;

    localparam logic [5:0] BRAKE_L  = 6'b111_000;
    localparam logic [5:0] BRAKE_R  = 6'b000_111;

    function automatic logic [5:0] lamp_decode(input state_t s, input logic brake);
        logic [5:0] pat;
        pat = LAMP_OFF;
        unique case (s)
            StL1:    pat = LAMP_L1;
            StL2:    pat = LAMP_L2;
            StL3:    pat = LAMP_L3;
            StR1:    pat = LAMP_R1;
            StR2:    pat = LAMP_R2;
            StR3:    pat = LAMP_R3;
            StHazOn: pat = LAMP_ALL;
            default: pat = LAMP_OFF;
        endcase
        // Brake lights the bank not used for signalling; hazard states ignore it.
        if (brake) begin
            if (s == StIdle) begin
                pat = LAMP_ALL;
            end else if (s == StL1 || s == StL2 || s == StL3) begin
                pat = pat | BRAKE_R;
            end else if (s == StR1 || s == StR2 || s == StR3) begin
                pat = pat | BRAKE_L;
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running step prescaler.
//   clk   : system clock
//   reset : asynchronous active-high reset, count returns to 0
//   tick  : high for the one cycle where the count equals TICK_DIV-1
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned CNT_W    = 24
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [CNT_W-1:0] r_count;
    logic             w_wrap;

    assign w_wrap = (r_count == CNT_W'(TICK_DIV - 1));
    assign tick   = w_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/taillight_sequencer.sv
// Thunderbird tail-lamp sequencer: latches turn requests, arbitrates between
// left, right and hazard, steps the lamp pattern on prescaler ticks and
// applies the brake overlay.
//   clk, reset          : clock, asynchronous active-high reset
//   left, right         : turn requests (pulse or level), latched until served
//   hazard, brake       : level-sensitive requests
//   la/lb/lc, ra/rb/rc  : lamp drivers, inner to outer
//   busy                : high whenever the FSM is not idle
module taillight_sequencer
    import thunderbird_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned CNT_W    = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic left,
    input  logic right,
    input  logic hazard,
    input  logic brake,
    output logic la,
    output logic lb,
    output logic lc,
    output logic ra,
    output logic rb,
    output logic rc,
    output logic busy
);

    state_t     r_state;
    state_t     w_next;
    logic       w_tick;
    logic       r_pend_l;
    logic       r_pend_r;
    logic       w_clr_l;
    logic       w_clr_r;
    logic [5:0] r_lamps;
    logic       r_busy;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    always_comb begin
        w_next = r_state;
        if (w_tick) begin
            if (hazard && r_state != StHazOn && r_state != StHazOff) begin
                w_next = StHazOn;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (r_pend_l && r_pend_r) begin
                            w_next = StHazOn;
                        end else if (r_pend_l) begin
                            w_next = StL1;
                        end else if (r_pend_r) begin
                            w_next = StR1;
                        end
                    end
                    StL1:     w_next = StL2;
                    StL2:     w_next = StL3;
                    StL3:     w_next = StIdle;
                    StR1:     w_next = StR2;
                    StR2:     w_next = StR3;
                    StR3:     w_next = StIdle;
                    StHazOn:  w_next = StHazOff;
                    StHazOff: w_next = hazard ? StHazOn : StIdle;
                    default:  w_next = StIdle;
                endcase
            end
        end
    end

    // On a tick, next==L1/R1/HazOn can only mean the state is being entered.
    assign w_clr_l = w_tick && (w_next == StL1 || w_next == StHazOn);
    assign w_clr_r = w_tick && (w_next == StR1 || w_next == StHazOn);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_pend_l <= 1'b0;
            r_pend_r <= 1'b0;
            r_lamps  <= LAMP_OFF;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next;
            // A still-held request re-arms the latch on the same edge it is served.
            r_pend_l <= left || (r_pend_l && !w_clr_l);
            r_pend_r <= right || (r_pend_r && !w_clr_r);
            r_lamps  <= lamp_decode(w_next, brake);
            r_busy   <= (w_next != StIdle);
        end
    end

    assign {lc, lb, la, ra, rb, rc} = r_lamps;
    assign busy = r_busy;

endmodule

// File: tb/tb_taillight_sequencer.sv
module tb_taillight_sequencer;

    localparam int TICK_DIV = 4;

    localparam int M_IDLE  = 0;
    localparam int M_LEFT  = 1;
    localparam int M_RIGHT = 2;
    localparam int M_HAZ   = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic left = 1'b0;
    logic right = 1'b0;
    logic hazard = 1'b0;
    logic brake = 1'b0;
    logic la, lb, lc, ra, rb, rc, busy;
    logic [6:0] dut_vec;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode + step number, plain arithmetic for lamp bars.
    int         m_cnt;
    int         m_mode;
    int         m_step;
    bit         m_pl;
    bit         m_pr;
    bit         m_ticked;
    logic [6:0] m_exp;

    typedef struct {
        logic       l;
        logic       r;
        logic       h;
        logic       b;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    taillight_sequencer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (24)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .left   (left),
        .right  (right),
        .hazard (hazard),
        .brake  (brake),
        .la     (la),
        .lb     (lb),
        .lc     (lc),
        .ra     (ra),
        .rb     (rb),
        .rc     (rc),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    assign dut_vec = {la, lb, lc, ra, rb, rc, busy};

    task automatic model_reset();
        m_cnt = 0;
        m_mode = M_IDLE;
        m_step = 0;
        m_pl = 1'b0;
        m_pr = 1'b0;
        m_ticked = 1'b0;
        m_exp = '0;
    endtask

    task automatic model_step();
        bit tick;
        int nm;
        int ns;
        bit enter_on;
        int lft;
        int rgt;
        tick = (m_cnt == TICK_DIV - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        nm = m_mode;
        ns = m_step;
        if (tick) begin
            if (hazard && m_mode != M_HAZ) begin
                nm = M_HAZ;
                ns = 1;
            end else begin
                case (m_mode)
                    M_IDLE: begin
                        if (m_pl && m_pr) begin
                            nm = M_HAZ; ns = 1;
                        end else if (m_pl) begin
                            nm = M_LEFT; ns = 1;
                        end else if (m_pr) begin
                            nm = M_RIGHT; ns = 1;
                        end
                    end
                    M_LEFT, M_RIGHT: begin
                        if (m_step == 3) begin
                            nm = M_IDLE; ns = 0;
                        end else begin
                            ns = m_step + 1;
                        end
                    end
                    default: begin
                        if (m_step == 1) begin
                            ns = 0;
                        end else if (hazard) begin
                            ns = 1;
                        end else begin
                            nm = M_IDLE; ns = 0;
                        end
                    end
                endcase
            end
        end
        enter_on = tick && nm == M_HAZ && ns == 1;
        m_pl = left || (m_pl && !(enter_on || (tick && nm == M_LEFT && ns == 1)));
        m_pr = right || (m_pr && !(enter_on || (tick && nm == M_RIGHT && ns == 1)));
        m_mode = nm;
        m_step = ns;
        m_ticked = tick;
        lft = 0;
        rgt = 0;
        if (m_mode == M_LEFT) lft = (1 << m_step) - 1;
        if (m_mode == M_RIGHT) rgt = (1 << m_step) - 1;
        if (m_mode == M_HAZ && m_step == 1) begin
            lft = 7; rgt = 7;
        end
        if (brake) begin
            if (m_mode == M_IDLE) begin
                lft = 7; rgt = 7;
            end else if (m_mode == M_LEFT) begin
                rgt = 7;
            end else if (m_mode == M_RIGHT) begin
                lft = 7;
            end
        end
        m_exp = {lft[0], lft[1], lft[2], rgt[0], rgt[1], rgt[2], m_mode != M_IDLE};
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Steps until the edge just taken was a tick edge (bounded by TICK_DIV).
    task automatic to_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!m_ticked && n < TICK_DIV);
    endtask

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic add(input int n, input logic l, input logic r, input logic h,
                       input logic b, input logic [6:0] exp);
        vec_t v;
        v.l = l; v.r = r; v.h = h; v.b = b; v.exp = exp;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        // {la,lb,lc,ra,rb,rc,busy} per cycle after reset release; ticks on every 4th edge.
        add(1, 1, 0, 0, 0, 7'b000000_0);   // left pulse
        add(2, 0, 0, 0, 0, 7'b000000_0);
        add(4, 0, 0, 0, 0, 7'b100000_1);   // L1
        add(4, 0, 0, 0, 0, 7'b110000_1);   // L2
        add(4, 0, 0, 0, 0, 7'b111000_1);   // L3
        add(1, 0, 0, 0, 0, 7'b000000_0);   // back to idle
        add(1, 1, 0, 0, 0, 7'b000000_0);   // left and right in one window
        add(1, 0, 1, 0, 0, 7'b000000_0);
        add(1, 0, 0, 0, 0, 7'b000000_0);
        add(4, 0, 0, 0, 0, 7'b111111_1);   // HAZ_ON
        add(4, 0, 0, 0, 0, 7'b000000_1);   // HAZ_OFF
        add(2, 0, 0, 0, 0, 7'b000000_0);
        add(1, 0, 0, 0, 1, 7'b111111_0);   // brake in idle
        add(1, 0, 0, 0, 0, 7'b000000_0);
        add(1, 0, 0, 0, 0, 7'b000000_0);   // tick with nothing pending

        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", dut_vec, 7'b000000_0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            left = tbl[i].l; right = tbl[i].r; hazard = tbl[i].h; brake = tbl[i].b;
            step();
            check($sformatf("table[%0d]", i), dut_vec, tbl[i].exp);
        end
        check("pend_cleared", {5'b0, dut.r_pend_l, dut.r_pend_r}, 7'b0);

        // Right held, hazard raised during R2.
        right = 1'b1;
        to_tick(); check("r1", dut_vec, 7'b000100_1);
        to_tick(); check("r2", dut_vec, 7'b000110_1);
        hazard = 1'b1;
        to_tick(); check("haz_on1", dut_vec, 7'b111111_1);
        to_tick(); check("haz_off1", dut_vec, 7'b000000_1);
        to_tick(); check("haz_on2", dut_vec, 7'b111111_1);
        hazard = 1'b0;
        to_tick(); check("haz_off2", dut_vec, 7'b000000_1);
        to_tick(); check("haz_idle", dut_vec, 7'b000000_0);
        right = 1'b0;
        to_tick(); check("r1_resume", dut_vec, 7'b000100_1);
        to_tick(); check("r2_resume", dut_vec, 7'b000110_1);
        to_tick(); check("r3_resume", dut_vec, 7'b000111_1);
        to_tick(); check("r_idle", dut_vec, 7'b000000_0);
        to_tick(); check("r_stay_idle", dut_vec, 7'b000000_0);

        // Brake during L2, then brake in HAZ_OFF.
        left = 1'b1; step(); left = 1'b0;
        to_tick(); check("bl_l1", dut_vec, 7'b100000_1);
        to_tick(); check("bl_l2", dut_vec, 7'b110000_1);
        brake = 1'b1; step(); check("brake_l2", dut_vec, 7'b110111_1);
        brake = 1'b0; step(); check("brake_l2_off", dut_vec, 7'b110000_1);
        to_tick(); check("bl_l3", dut_vec, 7'b111000_1);
        to_tick(); check("bl_idle", dut_vec, 7'b000000_0);
        hazard = 1'b1;
        to_tick(); check("bh_on", dut_vec, 7'b111111_1);
        hazard = 1'b0;
        to_tick(); check("bh_off", dut_vec, 7'b000000_1);
        brake = 1'b1; step(); check("brake_hazoff", dut_vec, 7'b000000_1);
        brake = 1'b0;
        to_tick(); check("bh_idle", dut_vec, 7'b000000_0);

        // Asynchronous reset in the middle of L3.
        left = 1'b1; step(); left = 1'b0;
        to_tick(); to_tick(); to_tick();
        check("pre_rst_l3", dut_vec, 7'b111000_1);
        step();
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", dut_vec, 7'b000000_0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("post_rst_idle[%0d]", i), dut_vec, 7'b000000_0);
        end
        left = 1'b1; step(); left = 1'b0;
        to_tick(); check("post_rst_l1", dut_vec, 7'b100000_1);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            left = ($urandom_range(0, 7) == 0);
            right = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) hazard = ~hazard;
            if ($urandom_range(0, 11) == 0) brake = ~brake;
            step();
            check($sformatf("rand[%0d]", i), dut_vec, m_exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
